add_accumulator: RTL
====================

// Module: add_accumulator
// PURPOSE
//   Stream accumulator stage downstream of the ripple Adder.
//   - Accepts a stream of N-bit operands over a valid/ready handshake.
//   - Sums each packet (terminated by in_last) into a widened register,
//     using an Adder instance of width ACC_W; the carry-out is unused.
//   - Presents the packet sum and beat count on a valid/ready output.
//   Sits between operand sources and the result consumer in the lab2 datapath.
// PARAMETERS
//   N      32  operand width (bits)
//   CNT_W  8   beat-counter width; max packet length = 2^CNT_W-1 beats
//   ACC_W  N+CNT_W (localparam)  accumulator width; by construction the sum never overflows
// PORTS
//   clk        in   1      single clock, rising edge
//   rst_n      in   1      asynchronous active-low reset
//   in_valid   in   1      operand beat valid
//   in_ready   out  1      stage can accept a beat
//   in_data    in   N      operand, unsigned
//   in_last    in   1      beat is the final one of its packet
//   out_valid  out  1      packet result valid
//   out_ready  in   1      consumer accepts the result
//   out_sum    out  ACC_W  unsigned packet sum
//   out_count  out  CNT_W  beats in the packet (1..2^CNT_W-1)
//   out_trunc  out  1      packet was force-closed at the maximum length
// BEHAVIOUR
//   Reset (async assert, sync release)
//     - State=IDLE; acc, cnt, out_sum, out_count = 0; out_valid = 0; out_trunc = 0.
//     - in_ready is low while rst_n=0, then follows the state rules below.
//   Handshakes
//     - Input beat accepted when in_valid && in_ready.
//     - Result taken when out_valid && out_ready.
//     - in_data and in_last are sampled only on acceptance.
//   FSM: IDLE, ACCUM, DONE
//     - IDLE: in_ready=1. On accept: acc<=zext(in_data), cnt<=1.
//       Next state is DONE if in_last, else ACCUM.
//     - ACCUM: in_ready=1. On accept: acc<=acc+zext(in_data), cnt<=cnt+1.
//       Next state is DONE if in_last or the new cnt == 2^CNT_W-1.
//       Without an accept, hold all state.
//     - DONE: in_ready=0, out_valid=1. out_sum, out_count and out_trunc are
//       registered copies of acc, cnt and the trunc flag, stable until the
//       result is taken. When taken, go to IDLE next cycle.
//   Force-close
//     - A beat reaching cnt == 2^CNT_W-1 without in_last is accumulated normally.
//     - The packet is then closed with out_trunc=1.
//     - Any following beats form a new packet.
//     - If in_last arrives on that same beat, out_trunc=0.
//   Timing
//     - Throughput: 1 beat/cycle inside a packet.
//     - out_valid rises the cycle after the closing beat is accepted.
//     - Exactly 1 bubble between packets: the DONE cycle with in_ready=0.
//     - out_valid is combinationally independent of out_ready.
//   Width rule: (2^CNT_W-1)*(2^N-1) < 2^ACC_W, so there is no wrap and no overflow flag.
//   Reset mid-packet: partial packet discarded, no output produced.
//   Holding in_valid=1 with in_ready=0 is legal; the data is not consumed.
// TESTING
//   1. Beats 1, 2, 3 (last on 3), out_ready=1 -> out_valid one cycle after beat 3;
//      out_sum=6, out_count=3, out_trunc=0.
//   2. Single beat 0xFFFFFFFF with last -> out_sum=0x00FFFFFFFF, out_count=1.
//   3. Packet 5+7 (last), out_ready=0 for 5 cycles -> out_valid stays 1, in_ready stays 0,
//      out_sum=12 held; IDLE the cycle after out_ready=1.
//   4. 255 beats of 0xFFFFFFFF, no last -> out_sum=0xFEFFFFFF01, out_count=255,
//      out_trunc=1; the 256th beat starts a new packet with out_count=1.
//   5. rst_n low after 2 beats of a packet -> all outputs 0 immediately;
//      next packet 4 (last) gives out_sum=4, out_count=1.
//   6. Back-to-back packets {10, 20 last} and {30 last}, in_valid held high ->
//      results 30 then 30, in_ready low exactly 1 cycle between packets, no beat lost.

Source files
------------

// File: rtl/add_accumulator.sv
// add_accumulator: sums valid/ready operand packets into a widened register and
// presents the sum, beat count and force-close flag on a valid/ready output.

module adder #(
  parameter int W = 8
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         cin_i,
  output logic [W-1:0] sum_o,
  output logic         cout_o
);
  logic carry;

  always_comb begin
    sum_o = '0;
    carry = cin_i;
    for (int i = 0; i < W; i++) begin
      sum_o[i] = a_i[i] ^ b_i[i] ^ carry;
      carry    = (a_i[i] & b_i[i]) | (carry & (a_i[i] ^ b_i[i]));
    end
    cout_o = carry;
  end
endmodule

// state | meaning
// IDLE  | waiting for the first beat of a packet
// ACCUM | packet open, adding beats into acc
// DONE  | result held on the output until taken; input stalled
module add_accumulator #(
  parameter int N     = 32,
  parameter int CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N-1:0]         in_data,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [N+CNT_W-1:0]   out_sum,
  output logic [CNT_W-1:0]     out_count,
  output logic                 out_trunc
);
  localparam int ACC_W = N + CNT_W;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, sum_q;
  logic [CNT_W-1:0]   cnt_q, count_q;
  logic               trunc_q;

  logic               accept, close;
  logic [ACC_W-1:0]   add_a, add_b, add_sum;
  logic [CNT_W-1:0]   cnt_nxt;
  logic               adder_cout_unused;

  assign accept  = in_valid && in_ready;
  // The first beat of a packet adds onto zero rather than the stale acc.
  assign add_a   = (state_q == S_ACCUM) ? acc_q : '0;
  assign add_b   = {{CNT_W{1'b0}}, in_data};
  assign cnt_nxt = (state_q == S_ACCUM) ? cnt_q + 1'b1 : CNT_W'(1);
  assign close   = accept && (in_last || (cnt_nxt == CNT_MAX));

  adder #(.W(ACC_W)) u_adder (
    .a_i   (add_a),
    .b_i   (add_b),
    .cin_i (1'b0),
    .sum_o (add_sum),
    .cout_o(adder_cout_unused)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_ACCUM: if (accept) state_d = close ? S_DONE : S_ACCUM;
      S_DONE:          if (out_ready) state_d = S_IDLE;
      default:         state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = rst_n && (state_q != S_DONE);
    out_valid = (state_q == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q   <= '0;
      cnt_q   <= '0;
      sum_q   <= '0;
      count_q <= '0;
      trunc_q <= 1'b0;
    end else begin
      if (accept) begin
        acc_q <= add_sum;
        cnt_q <= cnt_nxt;
      end
      if (close) begin
        sum_q   <= add_sum;
        count_q <= cnt_nxt;
        trunc_q <= !in_last;
      end
    end
  end

  assign out_sum   = sum_q;
  assign out_count = count_q;
  assign out_trunc = trunc_q;
endmodule
